icache_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer between the byte-addressed combinational instruction cache (32-bit little-endian words, 6-bit byte address) and the decode stage. It owns the fetch PC, drives the cache address, buffers fetched words in a small prefetch FIFO with a valid/ready handshake toward decode, and handles redirects (branch/jump) by flushing the queue. It also detects the all-ones halt word that terminates programs and stops fetching.

---
 rtl/icache_fetch_ctrl.sv | 90 +++++++++
 tb/tb_icache_fetch_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, buffers cache words in a prefetch FIFO toward decode.
// Define ICACHE_HALT_DETECT_EN to stop fetching when HALT_WORD is read.
module icache_fetch_ctrl #(
  parameter int               WIDTH     = 32,
  parameter int               WIDTH_ADD = 6,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [WIDTH_ADD-1:0] icache_addr,
  input  logic [WIDTH-1:0]     icache_data,
  input  logic                 redirect_valid,
  input  logic [WIDTH_ADD-1:0] redirect_addr,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [WIDTH-1:0]     instr_data,
  output logic [WIDTH_ADD-1:0] instr_pc,
  output logic                 halted
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
`ifdef ICACHE_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic [WIDTH-1:0]     fifo_data [DEPTH];
  logic [WIDTH_ADD-1:0] fifo_pc   [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     count;
  logic [WIDTH_ADD-1:0] fetch_pc;
  logic                 halt_seen;

  logic                 pop;
  logic                 fetch_slot;
  logic                 is_halt;
  logic                 push;
  logic                 halt_set;
  logic [WIDTH_ADD-1:0] redirect_pc;

  assign icache_addr = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr_data  = fifo_data[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
  assign halted      = HALT_EN && halt_seen && (count == '0);

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign pop         = instr_valid && instr_ready;
  assign fetch_slot  = !redirect_valid && !halt_seen && ((count < FULL_CNT) || pop);
  assign is_halt     = HALT_EN && (icache_data == HALT_WORD);
  assign push        = fetch_slot && !is_halt;
  assign halt_set    = fetch_slot && is_halt;
  assign redirect_pc = redirect_addr & ~WIDTH_ADD'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      halt_seen <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // Redirect squashes the queue, including any head decode accepts this cycle.
      fetch_pc  <= redirect_pc;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      halt_seen <= 1'b0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= icache_data;
        fifo_pc[wr_ptr]   <= fetch_pc;
        wr_ptr            <= wr_ptr + PTR_W'(1);
        fetch_pc          <= fetch_pc + WIDTH_ADD'(4);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (halt_set) halt_seen <= 1'b1;
    end
  end
endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Directed bench for icache_fetch_ctrl with a delivery-order scoreboard.
// Halt expectations follow ICACHE_HALT_DETECT_EN.
module tb_icache_fetch_ctrl;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  icache_addr;
  logic [31:0] icache_data;
  logic        redirect_valid;
  logic [5:0]  redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [5:0]  instr_pc;
  logic        halted;

  logic [31:0] prog [16];
  ent_t        sb [$];
  ent_t        mon_e;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  assign icache_data = prog[icache_addr[5:2]];

  icache_fetch_ctrl #(
    .WIDTH(32), .WIDTH_ADD(6), .DEPTH(4), .HALT_WORD(HALT_WORD)
  ) dut (
    .clk(clk), .rst(rst),
    .icache_addr(icache_addr), .icache_data(icache_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .halted(halted)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected delivery order from a fetch start address.
  task automatic load_sb(input logic [5:0] start);
    logic [5:0] pc;
    ent_t e;
    sb.delete();
    pc = start;
    for (int i = 0; i < 64; i++) begin
      e.data = prog[pc[5:2]];
      e.pc   = pc;
`ifdef ICACHE_HALT_DETECT_EN
      if (e.data == HALT_WORD) break;
`endif
      sb.push_back(e);
      pc = pc + 6'd4;
    end
  endtask

  task automatic do_redirect(input logic [5:0] addr, input logic [5:0] expect_start);
    load_sb(expect_start);
    redirect_valid = 1'b1;
    redirect_addr  = addr;
    tick();
    redirect_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && !redirect_valid && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_delivery", instr_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check("head_data", instr_data, mon_e.data);
        check("head_pc", instr_pc, mon_e.pc);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) prog[i] = 32'h1000_0000 + i * 32'h0011_0101;
    prog[0]  = 32'hE021_0001;
    prog[1]  = 32'hE801_0000;
    prog[13] = 32'h8000_0006;
    prog[14] = HALT_WORD;
    rst = 1'b1; redirect_valid = 1'b0; redirect_addr = '0; instr_ready = 1'b0;
    tick(); tick();
    check("rst_valid", instr_valid, 0);
    check("rst_addr", icache_addr, 0);
    check("rst_halted", halted, 0);
    check("rst_data", instr_data, 0);
    check("rst_pc", instr_pc, 0);

    load_sb(6'd0);
    rst = 1'b0; instr_ready = 1'b1;
    tick();
    check("first_valid", instr_valid, 1);
    check("first_pc", instr_pc, 0);
    check("first_data", instr_data, 32'hE021_0001);
    tick();
    check("second_pc", instr_pc, 4);
    check("second_data", instr_data, 32'hE801_0000);
    tick(); tick();

    instr_ready = 1'b0;
    do_redirect(6'd0, 6'd0);
    check("redir0_valid", instr_valid, 0);
    repeat (10) tick();
    check("stall_valid", instr_valid, 1);
    check("stall_addr", icache_addr, 16);
    check("stall_pc", instr_pc, 0);
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("b2b_valid", instr_valid, 1);
      check("b2b_pc", instr_pc, 4 * i);
      tick();
      if (i == 0) check("full_pushpop_addr", icache_addr, 20);
    end

    instr_ready = 1'b0;
    do_redirect(6'd40, 6'd40);
    repeat (3) tick();
    check("three_pc", instr_pc, 40);
    check("three_addr", icache_addr, 52);
    do_redirect(6'd27, 6'd24);
    check("redir_valid_drop", instr_valid, 0);
    check("redir_addr", icache_addr, 24);
    tick();
    check("redir_head_valid", instr_valid, 1);
    check("redir_head_pc", instr_pc, 24);
    instr_ready = 1'b1;

`ifdef ICACHE_HALT_DETECT_EN
    for (int i = 0; i < 40 && !halted; i++) tick();
    check("halted_set", halted, 1);
    check("halt_addr", icache_addr, 56);
    check("halt_drained", instr_valid, 0);
    check("halt_sb_drained", sb.size(), 0);
    tick();
    check("halt_addr_hold", icache_addr, 56);
`else
    repeat (12) tick();
    check("nohalt_addr", icache_addr, 12);
    check("nohalt_halted", halted, 0);
`endif
    do_redirect(6'd0, 6'd0);
    check("halt_cleared", halted, 0);
    check("redir0b_addr", icache_addr, 0);

    instr_ready = 1'b0;
    do_redirect(6'd60, 6'd60);
    check("wrap_start", icache_addr, 60);
    tick();
    check("wrap_addr", icache_addr, 0);
    check("wrap_pc", instr_pc, 60);
    repeat (6) tick();
    check("full_hold_addr", icache_addr, 12);
    instr_ready = 1'b1;
    tick();
    check("fullpp_addr", icache_addr, 16);
    check("fullpp_valid", instr_valid, 1);
    tick();
    check("fullpp_addr2", icache_addr, 20);

    rst = 1'b1; redirect_valid = 1'b1; redirect_addr = 6'd40;
    sb.delete();
    tick();
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_addr", icache_addr, 0);
    check("mid_rst_halted", halted, 0);
    check("mid_rst_data", instr_data, 0);
    check("mid_rst_pc", instr_pc, 0);
    load_sb(6'd0);
    rst = 1'b0; redirect_valid = 1'b0;
    repeat (3) tick();
    check("post_rst_pc", instr_pc, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
